// File: rtl/sev_seg_decoder.sv
// ---------------------------------------------------------------------------
// sev_seg_decoder
//
// Recovers the hex value shown on a multiplexed 4-digit seven-segment display
// by watching its cathode and anode buses. Each digit's pattern must stay
// stable for STABLE_CYCLES consecutive registered samples before it is
// decoded. A complete frame is reported once all four digits have been
// captured.
//
// Ports
//   CLK        system clock
//   RST        synchronous, active-high reset
//   CATHODES   {dp,a,b,c,d,e,f,g}, active-low (0 = segment lit)
//   ANODES     {d4,d3,d2,d1}, active-low digit select
//   DATA_OUT   last decoded frame, d4 in [15:12] ... d1 in [3:0]
//   DP_OUT     decimal point lit per digit, bit i = digit d(i+1)
//   VALID      one-cycle pulse when a full four-digit frame completes
//   ERR        one-cycle pulse on an illegal anode or segment pattern
//   BLANK_OUT  (only with SEV_SEG_DEC_BLANK_EN) digit captured as all-off
//
// Build option
//   SEV_SEG_DEC_BLANK_EN  when defined, an all-segments-off pattern is a
//                         legal digit (nibble 0, flagged on BLANK_OUT).
//                         When undefined it is reported through ERR.
// ---------------------------------------------------------------------------
module sev_seg_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  CATHODES,
  input  logic [3:0]  ANODES,
  output logic [15:0] DATA_OUT,
  output logic [3:0]  DP_OUT,
  output logic        VALID,
  output logic        ERR
`ifdef SEV_SEG_DEC_BLANK_EN
  ,
  output logic [3:0]  BLANK_OUT
`endif
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Registered input copy and its one-cycle-delayed twin used for change
  // detection. Nothing downstream looks at the raw pins.
  logic [7:0] cath_q, cath_prev;
  logic [3:0] an_q, an_prev;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [3:0] seen, seen_next;
  logic [15:0] data_next;
  logic [3:0] dp_next;
  logic       valid_next, err_next;
`ifdef SEV_SEG_DEC_BLANK_EN
  logic [3:0] blank_next;
`endif

  // Anode classification
  logic       an_idle, an_single;
  logic [1:0] an_idx;

  // Segment decode
  logic [6:0] lit;
  logic       dec_hit, blank_pat, seg_legal;
  logic [3:0] dec_nib, nibble;

  logic       changed, capture;
  logic [3:0] seen_upd;

  // Lit-segment pattern {a,b,c,d,e,f,g} -> {hit, nibble}
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   decode = {1'b1, 4'h0};
      7'h30:   decode = {1'b1, 4'h1};
      7'h6D:   decode = {1'b1, 4'h2};
      7'h79:   decode = {1'b1, 4'h3};
      7'h33:   decode = {1'b1, 4'h4};
      7'h5B:   decode = {1'b1, 4'h5};
      7'h5F:   decode = {1'b1, 4'h6};
      7'h70:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h7B:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h1F:   decode = {1'b1, 4'hB};
      7'h4E:   decode = {1'b1, 4'hC};
      7'h3D:   decode = {1'b1, 4'hD};
      7'h4F:   decode = {1'b1, 4'hE};
      7'h47:   decode = {1'b1, 4'hF};
      default: decode = {1'b0, 4'h0};
    endcase
  endfunction

  // NOTE: every variable driven here gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    an_idle   = (an_q == 4'b1111);
    an_single = 1'b0;
    an_idx    = 2'd0;
    case (an_q)
      4'b1110: begin an_single = 1'b1; an_idx = 2'd0; end
      4'b1101: begin an_single = 1'b1; an_idx = 2'd1; end
      4'b1011: begin an_single = 1'b1; an_idx = 2'd2; end
      4'b0111: begin an_single = 1'b1; an_idx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    lit = ~cath_q[6:0];
    {dec_hit, dec_nib} = decode(lit);
`ifdef SEV_SEG_DEC_BLANK_EN
    blank_pat = (lit == 7'd0);
`else
    blank_pat = 1'b0;
`endif
    seg_legal = dec_hit | blank_pat;
    nibble    = blank_pat ? 4'h0 : dec_nib;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    seen_next  = seen;
    data_next  = DATA_OUT;
    dp_next    = DP_OUT;
    valid_next = 1'b0;
    err_next   = 1'b0;
`ifdef SEV_SEG_DEC_BLANK_EN
    blank_next = BLANK_OUT;
`endif
    capture    = 1'b0;
    seen_upd   = seen | (4'b0001 << an_idx);
    changed    = ({cath_q, an_q} != {cath_prev, an_prev});

    if (changed) begin
      // Any change restarts the stability run, regardless of state.
      if (an_single) begin
        state_next = SETTLE;
        cnt_next   = 8'd1;
      end else begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        err_next   = ~an_idle;
      end
    end else begin
      case (state)
        SETTLE: begin
          cnt_next = cnt + 8'd1;
          if (cnt + 8'd1 == STABLE) begin
            capture    = 1'b1;
            state_next = HELD;
          end
        end
        // The counter stays at STABLE while held: it saturates, never wraps,
        // and no second capture happens until the input changes.
        HELD:    cnt_next = cnt;
        default: ;
      endcase
    end

    if (capture) begin
      if (seg_legal) begin
        data_next[{an_idx, 2'b00} +: 4] = nibble;
        dp_next[an_idx]                 = ~cath_q[7];
`ifdef SEV_SEG_DEC_BLANK_EN
        blank_next[an_idx]              = blank_pat;
`endif
        if (seen_upd == 4'b1111) begin
          valid_next = 1'b1;
          seen_next  = 4'b0000;
        end else begin
          seen_next  = seen_upd;
        end
      end else begin
        err_next = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cath_q    <= 8'hFF;
      an_q      <= 4'hF;
      cath_prev <= 8'hFF;
      an_prev   <= 4'hF;
      state     <= IDLE;
      cnt       <= 8'd0;
      seen      <= 4'b0000;
      DATA_OUT  <= 16'h0000;
      DP_OUT    <= 4'h0;
      VALID     <= 1'b0;
      ERR       <= 1'b0;
`ifdef SEV_SEG_DEC_BLANK_EN
      BLANK_OUT <= 4'h0;
`endif
    end else begin
      cath_q    <= CATHODES;
      an_q      <= ANODES;
      cath_prev <= cath_q;
      an_prev   <= an_q;
      state     <= state_next;
      cnt       <= cnt_next;
      seen      <= seen_next;
      DATA_OUT  <= data_next;
      DP_OUT    <= dp_next;
      VALID     <= valid_next;
      ERR       <= err_next;
`ifdef SEV_SEG_DEC_BLANK_EN
      BLANK_OUT <= blank_next;
`endif
    end
  end

endmodule

// File: tb/tb_sev_seg_decoder.sv
// ---------------------------------------------------------------------------
// tb_sev_seg_decoder
//
// Directed bench for sev_seg_decoder with STABLE_CYCLES = 16. Inputs change
// on the falling edge; outputs are sampled on the falling edge or 1 ns after
// the rising edge. A monitor keeps running totals of VALID/ERR pulses and
// flags any pulse longer than one cycle.
// ---------------------------------------------------------------------------
module tb_sev_seg_decoder;

  // Cathode patterns {dp,a..g}, active-low, decimal point off
  localparam logic [7:0] C1 = 8'hCF;
  localparam logic [7:0] C2 = 8'h92;
  localparam logic [7:0] C3 = 8'h86;
  localparam logic [7:0] C4 = 8'hCC;
  localparam logic [7:0] C5 = 8'hA4;
  localparam logic [7:0] C6 = 8'hA0;
  localparam logic [7:0] C7 = 8'h8F;
  localparam logic [7:0] C8 = 8'h80;
  localparam logic [7:0] C9 = 8'h84;
  localparam logic [7:0] CA = 8'h88;
  localparam logic [7:0] CB = 8'hE0;
  localparam logic [7:0] CC = 8'hB1;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  CATHODES;
  logic [3:0]  ANODES;
  logic [15:0] DATA_OUT;
  logic [3:0]  DP_OUT;
  logic        VALID;
  logic        ERR;
`ifdef SEV_SEG_DEC_BLANK_EN
  logic [3:0]  BLANK_OUT;
`endif

  int checks = 0;
  int errors = 0;

  int valid_tot = 0;
  int err_tot   = 0;
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;
  bit   long_pulse = 1'b0;

  sev_seg_decoder #(.STABLE_CYCLES(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CATHODES (CATHODES),
    .ANODES   (ANODES),
    .DATA_OUT (DATA_OUT),
    .DP_OUT   (DP_OUT),
    .VALID    (VALID),
    .ERR      (ERR)
`ifdef SEV_SEG_DEC_BLANK_EN
    ,
    .BLANK_OUT(BLANK_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (VALID) valid_tot++;
    if (ERR)   err_tot++;
    if ((VALID && prev_valid) || (ERR && prev_err)) long_pulse = 1'b1;
    prev_valid = VALID;
    prev_err   = ERR;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1 ms", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic hold(input logic [3:0] an, input logic [7:0] cath, input int n);
    ANODES   = an;
    CATHODES = cath;
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    hold(4'b1111, 8'hFF, n);
  endtask

  task automatic frame(input logic [7:0] c4, input logic [7:0] c3,
                       input logic [7:0] c2, input logic [7:0] c1, input int n);
    hold(4'b0111, c4, n);
    hold(4'b1011, c3, n);
    hold(4'b1101, c2, n);
    hold(4'b1110, c1, n);
  endtask

  task automatic do_reset();
    ANODES   = 4'b1111;
    CATHODES = 8'hFF;
    RST      = 1'b1;
    repeat (2) @(negedge CLK);
    RST      = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST      = 1'b1;
    ANODES   = 4'b1110;
    CATHODES = C8;
    repeat (3) @(negedge CLK);
    checks++; if (DATA_OUT !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", DATA_OUT); end
    checks++; if (DP_OUT !== 4'h0) begin errors++; $display("FAIL reset_dp: got %h want 0", DP_OUT); end
    checks++; if (VALID !== 1'b0 || ERR !== 1'b0) begin errors++; $display("FAIL reset_pulses: valid=%b err=%b want 0 0", VALID, ERR); end
`ifdef SEV_SEG_DEC_BLANK_EN
    checks++; if (BLANK_OUT !== 4'h0) begin errors++; $display("FAIL reset_blank: got %h want 0", BLANK_OUT); end
`endif
    ANODES   = 4'b1111;
    CATHODES = 8'hFF;
    @(negedge CLK);
    RST = 1'b0;
    idle(4);
  endtask

  task automatic test_frame();
    int v0 = valid_tot;
    int e0 = err_tot;
    hold(4'b0111, C1, 20);
    hold(4'b1011, C2, 20);
    hold(4'b1101, C3, 20);
    // Last digit stepped by hand: capture lands STABLE_CYCLES+1 = 17 cycles
    // after the pin change.
    ANODES   = 4'b1110;
    CATHODES = C4;
    repeat (16) @(negedge CLK);
    checks++; if (VALID !== 1'b0 || DATA_OUT !== 16'h1230) begin errors++; $display("FAIL latency_early: valid=%b data=%h want 0 1230", VALID, DATA_OUT); end
    @(negedge CLK);
    checks++; if (VALID !== 1'b1 || DATA_OUT !== 16'h1234) begin errors++; $display("FAIL latency_capture: valid=%b data=%h want 1 1234", VALID, DATA_OUT); end
    @(negedge CLK);
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: valid=%b want 0", VALID); end
    hold(4'b1110, C4, 2);
    idle(4);
    checks++; if (valid_tot - v0 != 1) begin errors++; $display("FAIL frame_valid_count: got %0d want 1", valid_tot - v0); end
    checks++; if (err_tot - e0 != 0) begin errors++; $display("FAIL frame_err_count: got %0d want 0", err_tot - e0); end
    checks++; if (DP_OUT !== 4'h0) begin errors++; $display("FAIL frame_dp: got %h want 0", DP_OUT); end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_tot;
    frame(C5, C6, C7, C8, 20);
    frame(C9, CA, CB, CC, 20);
    idle(4);
    checks++; if (valid_tot - v0 != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d want 2", valid_tot - v0); end
    checks++; if (DATA_OUT !== 16'h9ABC) begin errors++; $display("FAIL b2b_data: got %h want 9abc", DATA_OUT); end
  endtask

  task automatic test_short_hold();
    int v0 = valid_tot;
    hold(4'b0111, C5, 10);
    hold(4'b1011, C6, 20);
    hold(4'b1101, C7, 20);
    hold(4'b1110, C8, 20);
    idle(4);
    checks++; if (valid_tot - v0 != 0) begin errors++; $display("FAIL short_no_valid: got %0d want 0", valid_tot - v0); end
    checks++; if (DATA_OUT !== 16'h9678) begin errors++; $display("FAIL short_data: got %h want 9678", DATA_OUT); end
    frame(C5, C6, C7, C8, 20);
    idle(4);
    checks++; if (valid_tot - v0 != 1) begin errors++; $display("FAIL short_then_full_valid: got %0d want 1", valid_tot - v0); end
    checks++; if (DATA_OUT !== 16'h5678) begin errors++; $display("FAIL short_then_full_data: got %h want 5678", DATA_OUT); end
  endtask

  task automatic test_boundary();
    do_reset();
    idle(2);
    hold(4'b1110, C1, 15);
    idle(4);
    checks++; if (DATA_OUT !== 16'h0000) begin errors++; $display("FAIL hold15_no_capture: got %h want 0000", DATA_OUT); end
    hold(4'b1110, C1, 16);
    idle(4);
    checks++; if (DATA_OUT !== 16'h0001) begin errors++; $display("FAIL hold16_capture: got %h want 0001", DATA_OUT); end
  endtask

  task automatic test_recapture();
    int v0 = valid_tot;
    hold(4'b1110, C2, 20);
    checks++; if (DATA_OUT !== 16'h0002 || valid_tot != v0) begin errors++; $display("FAIL recapture_overwrite: data=%h valids=%0d want 0002 0", DATA_OUT, valid_tot - v0); end
    hold(4'b1101, C3, 20);
    hold(4'b1011, C4, 20);
    hold(4'b0111, C1, 20);
    idle(4);
    checks++; if (valid_tot - v0 != 1 || DATA_OUT !== 16'h1432) begin errors++; $display("FAIL recapture_frame: valids=%0d data=%h want 1 1432", valid_tot - v0, DATA_OUT); end
  endtask

  task automatic test_illegal_anodes();
    int v0 = valid_tot;
    int e0 = err_tot;
    hold(4'b0011, C1, 20);
    idle(4);
    checks++; if (err_tot - e0 != 1) begin errors++; $display("FAIL bad_anode_err: got %0d pulses want 1", err_tot - e0); end
    checks++; if (valid_tot - v0 != 0 || DATA_OUT !== 16'h1432) begin errors++; $display("FAIL bad_anode_data: valids=%0d data=%h want 0 1432", valid_tot - v0, DATA_OUT); end
  endtask

  task automatic test_illegal_segment();
    int v0 = valid_tot;
    int e0 = err_tot;
    // Held well past the stability window: still exactly one ERR.
    hold(4'b1110, 8'hFE, 40);
    idle(4);
    checks++; if (err_tot - e0 != 1) begin errors++; $display("FAIL bad_seg_err: got %0d pulses want 1", err_tot - e0); end
    checks++; if (DATA_OUT[3:0] !== 4'h2 || valid_tot != v0) begin errors++; $display("FAIL bad_seg_data: d1=%h valids=%0d want 2 0", DATA_OUT[3:0], valid_tot - v0); end
  endtask

  task automatic test_dp_reset();
    int v0;
    do_reset();
    v0 = valid_tot;
    frame(C1, C2, C3, 8'h4F, 20);
    idle(4);
    checks++; if (valid_tot - v0 != 1 || DATA_OUT !== 16'h1231) begin errors++; $display("FAIL dp_frame: valids=%0d data=%h want 1 1231", valid_tot - v0, DATA_OUT); end
    checks++; if (DP_OUT !== 4'h1) begin errors++; $display("FAIL dp_out: got %h want 1", DP_OUT); end
    hold(4'b0111, C5, 20);
    hold(4'b1011, C6, 20);
    hold(4'b1101, C7, 20);
    do_reset();
    checks++; if (DATA_OUT !== 16'h0000 || DP_OUT !== 4'h0 || VALID !== 1'b0 || ERR !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: data=%h dp=%h valid=%b err=%b want 0000 0 0 0", DATA_OUT, DP_OUT, VALID, ERR);
    end
    v0 = valid_tot;
    hold(4'b1110, C8, 20);
    idle(4);
    checks++; if (valid_tot - v0 != 0 || DATA_OUT !== 16'h0008) begin errors++; $display("FAIL after_reset_partial: valids=%0d data=%h want 0 0008", valid_tot - v0, DATA_OUT); end
    frame(C5, C6, C7, C8, 20);
    idle(4);
    checks++; if (valid_tot - v0 != 1 || DATA_OUT !== 16'h5678) begin errors++; $display("FAIL after_reset_full: valids=%0d data=%h want 1 5678", valid_tot - v0, DATA_OUT); end
  endtask

  task automatic test_blank();
    int v0;
    int e0;
    do_reset();
    v0 = valid_tot;
    e0 = err_tot;
    frame(8'hFF, C2, C3, C4, 20);
    idle(4);
`ifdef SEV_SEG_DEC_BLANK_EN
    checks++; if (valid_tot - v0 != 1 || err_tot != e0) begin errors++; $display("FAIL blank_pulses: valids=%0d errs=%0d want 1 0", valid_tot - v0, err_tot - e0); end
    checks++; if (DATA_OUT !== 16'h0234) begin errors++; $display("FAIL blank_data: got %h want 0234", DATA_OUT); end
    checks++; if (BLANK_OUT !== 4'h8) begin errors++; $display("FAIL blank_out: got %h want 8", BLANK_OUT); end
    frame(C1, C2, C3, C4, 20);
    idle(4);
    checks++; if (BLANK_OUT !== 4'h0) begin errors++; $display("FAIL blank_clear: got %h want 0", BLANK_OUT); end
`else
    checks++; if (valid_tot - v0 != 0 || err_tot - e0 != 1) begin errors++; $display("FAIL blank_illegal: valids=%0d errs=%0d want 0 1", valid_tot - v0, err_tot - e0); end
    checks++; if (DATA_OUT !== 16'h0234) begin errors++; $display("FAIL blank_illegal_data: got %h want 0234", DATA_OUT); end
`endif
  endtask

  task automatic test_pulse_width();
    checks++; if (long_pulse) begin errors++; $display("FAIL pulse_width: VALID or ERR high two cycles in a row, want single-cycle pulses"); end
  endtask

  initial begin
    RST      = 1'b1;
    ANODES   = 4'b1111;
    CATHODES = 8'hFF;
    @(negedge CLK);
    test_reset();
    test_frame();
    test_back_to_back();
    test_short_hold();
    test_boundary();
    test_recapture();
    test_illegal_anodes();
    test_illegal_segment();
    test_dp_reset();
    test_blank();
    test_pulse_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
